// File: rtl/rr_mux_n.sv
// N-channel, W-bit valid/ready multiplexer with fixed-select and round-robin
// modes, followed by a single output register stage.
module rr_mux_n #(
   parameter  int unsigned NCH  = 4,
   parameter  int unsigned W    = 8,
   localparam int unsigned SELW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [NCH*W-1:0]  in_data,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_ch_q, out_ch_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] ptr_q, ptr_d;

   logic            can_accept;
   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic [SELW-1:0] rr_idx;
   logic [W-1:0]    gnt_data;
   logic            load;

   assign can_accept = !out_valid_q || out_ready;

   // Grant selection: fixed index in mode 0, first valid after ptr in mode 1.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_idx  = '0;
      if (!mode) begin
         // Loop compare keeps an out-of-range sel from indexing past in_valid.
         for (int i = 0; i < int'(NCH); i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
      end else begin
         // Walk from farthest to nearest so the nearest valid channel wins.
         for (int k = int'(NCH); k >= 1; k--) begin
            rr_idx = SELW'((int'(ptr_q) + k) % int'(NCH));
            if (in_valid[rr_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = rr_idx;
            end
         end
      end
   end

   // Data of the granted channel.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_data = in_data[i*W +: W];
         end
      end
   end

   assign load = rst_n && can_accept && gnt_vld;

   // One-hot ready toward the granted channel; silent while in reset.
   always_comb begin
      in_ready = '0;
      if (load) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   // Next state of the output register and round-robin pointer.
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_data_d  = gnt_data;
         out_ch_d    = gnt_idx;
         out_valid_d = 1'b1;
         if (mode) begin
            ptr_d = gnt_idx;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset parks ptr on the last channel so search starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= SELW'(NCH - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: a 4-channel instance checked against a behavioural
// model, plus a 3-channel instance for out-of-range select checks.
module tb_rr_mux_n;

   logic        clk;
   logic        rst_n;

   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        mode3;
   logic [1:0]  sel3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

   int checks = 0;
   int errors = 0;

   // Model state for the 4-channel instance
   bit         mv;
   logic [7:0] md;
   int         mc;
   int         mptr;

   rr_mux_n #(.NCH(4), .W(8)) u4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   rr_mux_n #(.NCH(3), .W(8)) u3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode3),
      .sel       (sel3),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mv   = 1'b0;
      md   = 8'h00;
      mc   = 0;
      mptr = 3;
   endtask

   // Which channel the rules say should win this cycle.
   function automatic void exp_grant(output bit gv, output int g);
      gv = 1'b0;
      g  = 0;
      if (!mode) begin
         if (int'(sel) < 4 && in_valid[sel]) begin
            gv = 1'b1;
            g  = int'(sel);
         end
      end else begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (mptr + k) % 4;
            if (!gv && in_valid[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end
   endfunction

   // One clock: check ready before the edge, update model, check outputs after.
   task automatic tick(input string tag);
      bit         gv;
      int         g;
      logic [3:0] er;
      bit         acc;
      #1;
      exp_grant(gv, g);
      acc = !mv || out_ready;
      er  = '0;
      if (acc && gv) er[g] = 1'b1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
      @(posedge clk);
      if (acc && gv) begin
         md = in_data[g*8 +: 8];
         mc = g;
         mv = 1'b1;
         if (mode) mptr = g;
      end else if (mv && out_ready) begin
         mv = 1'b0;
      end
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mv));
      chk({tag, ".out_data"},  32'(out_data),  32'(md));
      chk({tag, ".out_ch"},    32'(out_ch),    32'(mc));
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      mode       = 1'b1;
      sel        = '0;
      in_data    = 32'h44332211;
      in_valid   = 4'hF;
      out_ready  = 1'b1;
      mode3      = 1'b0;
      sel3       = '0;
      in_data3   = 24'h332211;
      in_valid3  = 3'b000;
      out_ready3 = 1'b1;
      model_reset();

      // Reset state
      #2;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data",  32'(out_data),  32'd0);
      chk("rst.out_ch",    32'(out_ch),    32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd0);
      chk("rst.out_valid3", 32'(out_valid3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed select, single-bit payload in each lane
      mode    = 1'b0;
      in_data = {8'd1, 8'd0, 8'd1, 8'd0};
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick("fix_a");
      end
      in_data = {8'd1, 8'd0, 8'd0, 8'd0};
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick("fix_b");
      end

      // Round-robin ptr must still be at its reset value: start at ch0
      mode    = 1'b1;
      in_data = 32'h44332211;
      for (int i = 0; i < 5; i++) tick("rr_all");

      // Backpressure after a load
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick("bp_hold");
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) tick("bp_rel");

      // Sparse round-robin and wrap
      in_valid = 4'b1010;
      for (int i = 0; i < 3; i++) tick("rr_sparse");
      in_valid = 4'b0001;
      for (int i = 0; i < 2; i++) tick("rr_wrap");

      // Idle drain
      in_valid = 4'b0000;
      tick("idle");

      // Out-of-range sel on the 3-channel instance
      in_valid3 = 3'b111;
      sel3      = 2'd3;
      #1;
      chk("nch3.sel3.in_ready", 32'(in_ready3), 32'd0);
      tick("nch3_bg");
      chk("nch3.sel3.out_valid", 32'(out_valid3), 32'd0);
      sel3 = 2'd2;
      #1;
      chk("nch3.sel2.in_ready", 32'(in_ready3), 32'b100);
      tick("nch3_bg");
      chk("nch3.sel2.out_valid", 32'(out_valid3), 32'd1);
      chk("nch3.sel2.out_ch",    32'(out_ch3),    32'd2);
      chk("nch3.sel2.out_data",  32'(out_data3),  32'h33);
      in_valid3 = 3'b000;

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         tick("rand");
      end

      // Asynchronous reset while a word is held
      mode      = 1'b1;
      in_valid  = 4'hF;
      in_data   = 32'h44332211;
      out_ready = 1'b0;
      tick("pre_rst");
      chk("pre_rst.held", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.out_data",  32'(out_data),  32'd0);
      chk("arst.out_ch",    32'(out_ch),    32'd0);
      chk("arst.in_ready",  32'(in_ready),  32'd0);
      model_reset();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick("post_rst");
      chk("post_rst.first_ch", 32'(out_ch), 32'd0);
      tick("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
